// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory port arbiter: FSM states and master ids.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Combinational grant selection for mem_bus_arbiter: lock, fixed priority or round robin.
// Round robin between simultaneous requesters is enabled by MEM_BUS_ARB_RR_EN.
module mem_bus_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic ibus_req,
  input  logic dbus_req,
  input  logic lock_valid,
  input  gnt_e lock_gnt,
`ifdef MEM_BUS_ARB_RR_EN
  input  gnt_e last_grant,
`endif
  output logic gnt_valid,
  output gnt_e gnt
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = GNT_IBUS;
    if (lock_valid) begin
      // A stalled handshake keeps its master; if that master gave up, nobody is granted.
      gnt       = lock_gnt;
      gnt_valid = (lock_gnt == GNT_DBUS) ? dbus_req : ibus_req;
    end else if (dbus_req && ibus_req) begin
      gnt_valid = 1'b1;
`ifdef MEM_BUS_ARB_RR_EN
      gnt = (last_grant == GNT_DBUS) ? GNT_IBUS : GNT_DBUS;
`else
      gnt = GNT_DBUS;
`endif
    end else if (dbus_req) begin
      gnt_valid = 1'b1;
      gnt       = GNT_DBUS;
    end else if (ibus_req) begin
      gnt_valid = 1'b1;
      gnt       = GNT_IBUS;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch (ibus) and the LSU (dbus), one read in flight.
// Optional round-robin arbitration: define MEM_BUS_ARB_RR_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ibus_read,
  input  logic [AW-1:0]   ibus_address,
  output logic            ibus_waitrequest,
  output logic            ibus_readdatavalid,
  input  logic            dbus_read,
  input  logic            dbus_write,
  input  logic [AW-1:0]   dbus_address,
  input  logic [DW-1:0]   dbus_writedata,
  input  logic [DW/8-1:0] dbus_byteenable,
  output logic            dbus_waitrequest,
  output logic            dbus_readdatavalid,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_writedata,
  output logic [DW/8-1:0] mem_byteenable,
  input  logic            mem_waitrequest,
  input  logic [DW-1:0]   mem_readdata,
  input  logic            mem_readdatavalid
);

  arb_state_e state_reg, state_next;
  logic       lock_reg, lock_next;
  gnt_e       lock_gnt_reg, lock_gnt_next;
`ifdef MEM_BUS_ARB_RR_EN
  gnt_e       last_grant_reg, last_grant_next;
`endif
  logic       idle;
  logic       gnt_valid;
  gnt_e       gnt;
  logic       is_read;
  logic       unused_readdata;

  // Read data reaches the masters directly; only its valid strobe is routed here.
  assign unused_readdata = ^mem_readdata;

  // Gating with rst_b keeps the memory strobes quiet while reset is held.
  assign idle = rst_b && (state_reg == IDLE);

  mem_bus_arb_pick u_pick (
    .ibus_req   (idle && ibus_read),
    .dbus_req   (idle && (dbus_read || dbus_write)),
    .lock_valid (lock_reg),
    .lock_gnt   (lock_gnt_reg),
`ifdef MEM_BUS_ARB_RR_EN
    .last_grant (last_grant_reg),
`endif
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg      <= IDLE;
      lock_reg       <= 1'b0;
      lock_gnt_reg   <= GNT_IBUS;
`ifdef MEM_BUS_ARB_RR_EN
      last_grant_reg <= GNT_IBUS;
`endif
    end else begin
      state_reg      <= state_next;
      lock_reg       <= lock_next;
      lock_gnt_reg   <= lock_gnt_next;
`ifdef MEM_BUS_ARB_RR_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  always_comb begin
    state_next         = state_reg;
    lock_next          = lock_reg;
    lock_gnt_next      = lock_gnt_reg;
`ifdef MEM_BUS_ARB_RR_EN
    last_grant_next    = last_grant_reg;
`endif
    is_read            = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    mem_address        = '0;
    mem_writedata      = '0;
    mem_byteenable     = '1;
    ibus_waitrequest   = 1'b1;
    dbus_waitrequest   = 1'b1;
    ibus_readdatavalid = 1'b0;
    dbus_readdatavalid = 1'b0;

    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt == GNT_DBUS) begin
            // A simultaneous read+write is treated as a write.
            mem_write        = dbus_write;
            mem_read         = dbus_read && !dbus_write;
            mem_address      = dbus_address;
            mem_writedata    = dbus_writedata;
            mem_byteenable   = dbus_byteenable;
            dbus_waitrequest = mem_waitrequest;
            is_read          = !dbus_write;
          end else begin
            mem_read         = 1'b1;
            mem_address      = ibus_address;
            ibus_waitrequest = mem_waitrequest;
            is_read          = 1'b1;
          end
          if (mem_waitrequest) begin
            lock_next     = 1'b1;
            lock_gnt_next = gnt;
          end else begin
            lock_next = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
            last_grant_next = gnt;
`endif
            if (is_read) state_next = (gnt == GNT_DBUS) ? DRD : IRD;
          end
        end else begin
          lock_next = 1'b0;
        end
      end
      IRD: begin
        if (mem_readdatavalid) begin
          ibus_readdatavalid = 1'b1;
          state_next         = IDLE;
        end
      end
      DRD: begin
        if (mem_readdatavalid) begin
          dbus_readdatavalid = 1'b1;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name:
mem_bus_arbiter

Overview:
- Shares one memory port between the instruction-fetch master (ibus, read-only) and the LSU master (dbus, read/write).
- Sits between the core and the single-port RAM. Its dbus_waitrequest is the source of the core's data-bus-busy stall into the hazard detection unit.
- Allows at most one outstanding read. Read data is broadcast on mem_readdata; this block routes only the valid strobe.

Parameters:
AW, 32, address width for all three ports
DW, 32, data width; byteenable width is DW/8

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
ibus_read  in  1  fetch read request
ibus_address  in  AW  fetch address
ibus_waitrequest  out  1  fetch request not accepted this cycle
ibus_readdatavalid  out  1  mem_readdata belongs to ibus this cycle
dbus_read  in  1  LSU read request
dbus_write  in  1  LSU write request
dbus_address  in  AW  LSU address
dbus_writedata  in  DW  LSU write data
dbus_byteenable  in  DW/8  LSU byte enables
dbus_waitrequest  out  1  LSU request not accepted this cycle
dbus_readdatavalid  out  1  mem_readdata belongs to dbus this cycle
mem_read  out  1  shared read strobe
mem_write  out  1  shared write strobe
mem_address  out  AW  muxed address
mem_writedata  out  DW  dbus_writedata when dbus is granted, else 0
mem_byteenable  out  DW/8  dbus_byteenable when dbus is granted, all-ones for ibus
mem_waitrequest  in  1  memory stall
mem_readdata  in  DW  read data, wired directly to both masters outside this block
mem_readdatavalid  in  1  read data valid

Behaviour:
- **States.** IDLE, IRD and DRD. Reset puts the block in IDLE with the lock cleared and last_grant = ibus. While in reset: mem_read = 0, mem_write = 0, both readdatavalid = 0, both waitrequest = 1.
- **IDLE arbitration.** Arbitration is combinational from the requests. Fixed priority: dbus (read or write) beats ibus.
- **Granted master.** mem_* is driven from the granted master. The granted master's waitrequest equals mem_waitrequest; the other master's waitrequest = 1. With no request, mem_read = mem_write = 0 and both waitrequest = 1.
- **Grant lock.** If a granted request sees mem_waitrequest = 1, the lock flop holds that grant in following cycles, ignoring other requests, until the request is accepted (mem_waitrequest = 0). The address must never change mid-handshake.
- **Writes.** An accepted write completes on acceptance. The block stays in IDLE, so back-to-back writes run one per cycle.
- **Reads.** An accepted read moves to IRD or DRD on the next edge. In IRD/DRD: mem_read = mem_write = 0 and both waitrequest = 1.
- **Read return.** When mem_readdatavalid = 1 in IRD/DRD, assert the matching *_readdatavalid in that same cycle and return to IDLE on the next edge. No new grant is issued in the return cycle. Minimum read-to-read spacing is memory latency + 1.
- **Spurious valid.** mem_readdatavalid while in IDLE is ignored; neither *_readdatavalid asserts.
- **Illegal request.** dbus_read & dbus_write together is illegal; write takes precedence (mem_read = 0).
- **Reset mid-read.** Return to IDLE. A later mem_readdatavalid is dropped.

Optional Feature:
- MEM_BUS_ARB_RR_EN defined: when both masters request in IDLE (no lock), grant the master not recorded in last_grant. last_grant updates on every accepted request, and reset value ibus means dbus wins first.
- Undefined: fixed dbus priority; the last_grant flop is absent.

Decomposition:
- Shared core package: state enum {IDLE, IRD, DRD} and the master-id enum {GNT_IBUS, GNT_DBUS}.
- One natural sub-module, mem_bus_arb_pick: combinational grant selection from the requests, lock and last_grant; holds the round-robin logic.

Test Plan:
- **Back-to-back writes.** dbus_write 0x100/0xAA then 0x104/0xBB, with mem_waitrequest = 0 -> two mem_write pulses on consecutive cycles; ibus_waitrequest stays 1.
- **Read collision.** ibus_read 0x0 and dbus_read 0x200 together; memory latency 2 -> dbus granted first; dbus_readdatavalid with 0x12345678; ibus accepted one cycle after the return.
- **Lock.** ibus_read 0x40 with mem_waitrequest = 1 for 3 cycles; dbus_write arrives in cycle 1 -> mem_address stays 0x40 until acceptance; the dbus write goes next.
- **Round robin.** With MEM_BUS_ARB_RR_EN, both masters request reads continuously -> grants alternate dbus, ibus, dbus, ibus.
- **Reset mid-read.** rst_b low during DRD, then mem_readdatavalid = 1 after release -> neither readdatavalid asserts; state IDLE.
